// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bus bundle for the multi-port register file.
//
// Groups the write port, the packed read ports and the clear handshake.
//   master : the datapath side (drives addresses/data/strobes, takes read data)
//   slave  : the register file itself
// Packed read vectors carry port 0 in the least significant bits.
interface regfile_mp_if #(
  parameter int WIDTH  = 64,
  parameter int AW     = 5,
  parameter int RPORTS = 2
);
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [RPORTS-1:0]         rd_en;
  logic [RPORTS*AW-1:0]      rd_addr;
  logic [RPORTS*WIDTH-1:0]   rd_data;
  logic [RPORTS-1:0]         rd_valid;
  logic                      clr_req;
  logic                      busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised register file: one write port, RPORTS clocked
// read ports, a hardwired-zero register and a bulk-clear sequencer.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset; zeroes every entry and output
//   bus     : regfile_mp_if.slave (write port, read ports, clr_req / busy)
//
// Optional feature: define REGFILE_BYPASS_EN for write-first behaviour when a
// read and an accepted write hit the same address on the same edge. Without
// it, a same-edge read returns the old contents (read-first).
//
// The interface instance must use WIDTH, AW = $clog2(DEPTH) and RPORTS
// matching this module's parameters.
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int RPORTS   = 2,
  parameter int ZERO_REG = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile_mp_if.slave   bus
);
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                     state_reg;
  logic [AW-1:0]              clr_idx_reg;
  logic                       busy_reg;
  logic [WIDTH-1:0]           mem [DEPTH];
  logic [RPORTS*WIDTH-1:0]    rd_data_reg;
  logic [RPORTS-1:0]          rd_valid_reg;
  logic [WIDTH-1:0]           rd_next [RPORTS];
  logic                       wr_accept;

  // Writes are dropped (not queued) while the clear sweep runs.
  assign wr_accept = bus.wr_en && !busy_reg && (bus.wr_addr != ZERO_ADDR);

  // Clear sequencer: busy covers exactly the DEPTH sweeping edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      clr_idx_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.clr_req) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        CLEAR: begin
          clr_idx_reg <= clr_idx_reg + AW'(1);
          if (clr_idx_reg == LAST_IDX) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Storage. A write on the same edge that samples clr_req lands first and
  // is then zeroed by the sweep, since the sweep starts on the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_reg == CLEAR) begin
      mem[clr_idx_reg] <= '0;
    end else if (wr_accept) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Per-port read selection. The zero register is masked here rather than
  // relying on its storage, so it reads 0 regardless of bypass.
  for (genvar gi = 0; gi < RPORTS; gi++) begin : g_rd
    logic [AW-1:0] port_addr;
    assign port_addr = bus.rd_addr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_next[gi] = (port_addr == ZERO_ADDR) ? '0 :
                         (wr_accept && (bus.wr_addr == port_addr)) ? bus.wr_data :
                         mem[port_addr];
`else
    assign rd_next[gi] = (port_addr == ZERO_ADDR) ? '0 : mem[port_addr];
`endif
  end

  // Read registers: data holds when the port is not strobed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= '0;
    end else begin
      for (int p = 0; p < RPORTS; p++) begin
        rd_valid_reg[p] <= bus.rd_en[p];
        if (bus.rd_en[p]) rd_data_reg[p*WIDTH +: WIDTH] <= rd_next[p];
      end
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.busy     = busy_reg;
endmodule
